// File: rtl/gcla.sv
// GCL-A memory engine: one command per clock into two pipelined no-wait SRAM banks sharing a DQ bus.
// Latency: command edge 0 -> address/control out after edge 0 -> data cycle after edge 2 -> LEDs after edge 4.
// Backpressure: none; every edge accepts a command, and a synced JMP1N turns incoming commands into NOPs.
// Ports: clk/reset_n (async active-low); gclop_in = {op[1:0], bank, addr, data};
//        A_A/A_B, WE_n_*, OE_n_*, ADV_* per bank; CE/BW/mode pins shared; DQ{a,b,c,d}_AB shared bus;
//        LED1 = last READ passed, LED2 = sticky mismatch; JMP1N halt and JMP1S LED-force jumpers.
module gcla #(
    parameter int A_size  = 18,
    parameter int DQ_size = 9
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [2+1+A_size+4*DQ_size-1:0]    gclop_in,
    output logic [A_size-1:0]                  A_A,
    output logic [A_size-1:0]                  A_B,
    output logic                               BWa_n,
    output logic                               BWb_n,
    output logic                               BWc_n,
    output logic                               BWd_n,
    output logic                               WE_n_A,
    output logic                               WE_n_B,
    output logic                               CE_n,
    output logic                               CE2,
    output logic                               CE2_n,
    output logic                               OE_n_A,
    output logic                               OE_n_B,
    output logic                               ADV_A,
    output logic                               ADV_B,
    output logic                               CKE_n,
    output logic                               ZZ,
    output logic                               FT_n,
    output logic                               MODE,
    inout  wire  [DQ_size-1:0]                 DQa_AB,
    inout  wire  [DQ_size-1:0]                 DQb_AB,
    inout  wire  [DQ_size-1:0]                 DQc_AB,
    inout  wire  [DQ_size-1:0]                 DQd_AB,
    output logic                               LED1,
    output logic                               LED2,
    input  logic                               JMP1N,
    input  logic                               JMP1S
);

    localparam int W = 4 * DQ_size;
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;

    typedef struct packed {
        logic [1:0]        op;
        logic              bank;
        logic [A_size-1:0] addr;
        logic [W-1:0]      data;
    } gclop_t;

    // Address is split off at issue; only these fields travel to the data cycle.
    typedef struct packed {
        logic [1:0]   op;
        logic         bank;
        logic [W-1:0] data;
    } pipe_t;

    gclop_t cmd;
    assign cmd = gclop_in;

    pipe_t             p1_d, p1_q, p2_d, p2_q, p3_d, p3_q;
    logic [A_size-1:0] a_a_d, a_a_q, a_b_d, a_b_q;
    logic              active_d, active_q;
    logic              jn_meta_d, jn_meta_q, jn_sync_d, jn_sync_q;
    logic              js_meta_d, js_meta_q, js_sync_d, js_sync_q;
    logic              cap_vld_d, cap_vld_q;
    logic [W-1:0]      cap_dat_d, cap_dat_q, cap_exp_d, cap_exp_q;
    logic              pass_d, pass_q, err_d, err_q;
    logic [W-1:0]      dq_in;
    logic              dq_oe;

    assign dq_in = {DQd_AB, DQc_AB, DQb_AB, DQa_AB};

    always_comb begin
        // Opcode 11 and halted commands both collapse to NOP here.
        p1_d = '0;
        if (!jn_sync_q && (cmd.op == OP_WR || cmd.op == OP_RD)) begin
            p1_d.op   = cmd.op;
            p1_d.bank = cmd.bank;
            p1_d.data = cmd.data;
        end
        p2_d = p1_q;
        p3_d = p2_q;

        // Idle banks keep their last address so the dummy read is stable.
        a_a_d = a_a_q;
        a_b_d = a_b_q;
        if (p1_d.op != OP_NOP) begin
            if (p1_d.bank) a_b_d = cmd.addr;
            else           a_a_d = cmd.addr;
        end

        active_d  = 1'b1;
        jn_meta_d = JMP1N;
        jn_sync_d = jn_meta_q;
        js_meta_d = JMP1S;
        js_sync_d = js_meta_q;

        // Read word is captured at the end of the data cycle, compared one edge later.
        cap_vld_d = (p3_q.op == OP_RD);
        cap_dat_d = dq_in;
        cap_exp_d = p3_q.data;

        pass_d = pass_q;
        err_d  = err_q;
        if (cap_vld_q) begin
            pass_d = (cap_dat_q == cap_exp_q);
            err_d  = err_q | (cap_dat_q != cap_exp_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_q      <= '0;
            p2_q      <= '0;
            p3_q      <= '0;
            a_a_q     <= '0;
            a_b_q     <= '0;
            active_q  <= 1'b0;
            jn_meta_q <= 1'b0;
            jn_sync_q <= 1'b0;
            js_meta_q <= 1'b0;
            js_sync_q <= 1'b0;
            cap_vld_q <= 1'b0;
            cap_dat_q <= '0;
            cap_exp_q <= '0;
            pass_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            p3_q      <= p3_d;
            a_a_q     <= a_a_d;
            a_b_q     <= a_b_d;
            active_q  <= active_d;
            jn_meta_q <= jn_meta_d;
            jn_sync_q <= jn_sync_d;
            js_meta_q <= js_meta_d;
            js_sync_q <= js_sync_d;
            cap_vld_q <= cap_vld_d;
            cap_dat_q <= cap_dat_d;
            cap_exp_q <= cap_exp_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
        end
    end

    // Chip enables and byte writes stay deselected until the first edge after reset.
    assign CE_n  = !active_q;
    assign CE2   = active_q;
    assign CE2_n = !active_q;
    assign BWa_n = !active_q;
    assign BWb_n = !active_q;
    assign BWc_n = !active_q;
    assign BWd_n = !active_q;
    assign CKE_n = 1'b0;
    assign ZZ    = 1'b0;
    assign FT_n  = 1'b1;
    assign MODE  = 1'b0;

    assign A_A    = a_a_q;
    assign A_B    = a_b_q;
    assign ADV_A  = 1'b0;
    assign ADV_B  = 1'b0;
    assign WE_n_A = !(p1_q.op == OP_WR && !p1_q.bank);
    assign WE_n_B = !(p1_q.op == OP_WR &&  p1_q.bank);
    assign OE_n_A = !(p3_q.op == OP_RD && !p3_q.bank);
    assign OE_n_B = !(p3_q.op == OP_RD &&  p3_q.bank);

    // SRAM drives only on a READ data cycle and gcla only on a WRITE one, so no overlap.
    assign dq_oe  = (p3_q.op == OP_WR);
    assign DQa_AB = dq_oe ? p3_q.data[DQ_size-1:0]           : {DQ_size{1'bz}};
    assign DQb_AB = dq_oe ? p3_q.data[2*DQ_size-1:DQ_size]   : {DQ_size{1'bz}};
    assign DQc_AB = dq_oe ? p3_q.data[3*DQ_size-1:2*DQ_size] : {DQ_size{1'bz}};
    assign DQd_AB = dq_oe ? p3_q.data[4*DQ_size-1:3*DQ_size] : {DQ_size{1'bz}};

    assign LED1 = js_sync_q | pass_q;
    assign LED2 = js_sync_q | err_q;

endmodule

// File: tb/tb_gcla.sv
module tb_gcla;
    localparam int AW = 18;
    localparam int WW = 36;
    localparam int CW = 2 + 1 + AW + WW;
    localparam logic [1:0]  NOP   = 2'b00;
    localparam logic [1:0]  WR    = 2'b01;
    localparam logic [1:0]  RD    = 2'b10;
    localparam logic [35:0] PROBE = 36'h5A5A5A5A5;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic [CW-1:0] gclop_in = '0;
    logic JMP1N = 1'b0, JMP1S = 1'b0;
    logic [AW-1:0] A_A, A_B;
    logic BWa_n, BWb_n, BWc_n, BWd_n, WE_n_A, WE_n_B, CE_n, CE2, CE2_n;
    logic OE_n_A, OE_n_B, ADV_A, ADV_B, CKE_n, ZZ, FT_n, MODE, LED1, LED2;
    wire [8:0] dqa, dqb, dqc, dqd;

    gcla dut (
        .clk(clk), .reset_n(reset_n), .gclop_in(gclop_in),
        .A_A(A_A), .A_B(A_B),
        .BWa_n(BWa_n), .BWb_n(BWb_n), .BWc_n(BWc_n), .BWd_n(BWd_n),
        .WE_n_A(WE_n_A), .WE_n_B(WE_n_B),
        .CE_n(CE_n), .CE2(CE2), .CE2_n(CE2_n),
        .OE_n_A(OE_n_A), .OE_n_B(OE_n_B), .ADV_A(ADV_A), .ADV_B(ADV_B),
        .CKE_n(CKE_n), .ZZ(ZZ), .FT_n(FT_n), .MODE(MODE),
        .DQa_AB(dqa), .DQb_AB(dqb), .DQc_AB(dqc), .DQd_AB(dqd),
        .LED1(LED1), .LED2(LED2), .JMP1N(JMP1N), .JMP1S(JMP1S)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SRAM bank models (environment) ----------------
    logic [35:0] sram_a [0:(1<<AW)-1];
    logic [35:0] sram_b [0:(1<<AW)-1];
    logic sa1_act = 0, sa1_we = 0, sa2_act = 0, sa2_we = 0;
    logic sb1_act = 0, sb1_we = 0, sb2_act = 0, sb2_we = 0;
    logic [AW-1:0] sa1_addr = '0, sa2_addr = '0, sb1_addr = '0, sb2_addr = '0;
    logic chip_on, bw_all, en_a, en_b, probe_en = 1'b0, tb_en;
    logic [35:0] tb_val, dq_rd;

    assign chip_on = !CE_n && CE2 && !CE2_n && !CKE_n;
    assign bw_all  = !BWa_n && !BWb_n && !BWc_n && !BWd_n;
    assign dq_rd   = {dqd, dqc, dqb, dqa};
    assign en_a    = sa2_act && !sa2_we && !OE_n_A;
    assign en_b    = sb2_act && !sb2_we && !OE_n_B;
    assign tb_en   = en_a || en_b || probe_en;
    assign tb_val  = probe_en ? PROBE : (en_a ? sram_a[sa2_addr] : sram_b[sb2_addr]);
    assign dqa = tb_en ? tb_val[8:0]   : 9'bz;
    assign dqb = tb_en ? tb_val[17:9]  : 9'bz;
    assign dqc = tb_en ? tb_val[26:18] : 9'bz;
    assign dqd = tb_en ? tb_val[35:27] : 9'bz;

    always @(posedge clk) begin
        sa1_act <= chip_on; sa1_we <= !WE_n_A && bw_all; sa1_addr <= A_A;
        sb1_act <= chip_on; sb1_we <= !WE_n_B && bw_all; sb1_addr <= A_B;
        sa2_act <= sa1_act; sa2_we <= sa1_we; sa2_addr <= sa1_addr;
        sb2_act <= sb1_act; sb2_we <= sb1_we; sb2_addr <= sb1_addr;
        if (sa2_act && sa2_we) sram_a[sa2_addr] <= dq_rd;
        if (sb2_act && sb2_we) sram_b[sb2_addr] <= dq_rd;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: program-order memory, LED result due four edges after issue.
    typedef struct { int due; logic pass; } pend_t;
    pend_t pend[$];
    logic [35:0] mem_m [int];
    logic led1_m = 1'b0, led2_m = 1'b0;

    function automatic int key(input logic b, input logic [AW-1:0] a);
        return {13'd0, b, a};
    endfunction

    function automatic logic [35:0] mem_rd(input logic b, input logic [AW-1:0] a);
        return mem_m.exists(key(b, a)) ? mem_m[key(b, a)] : 36'd0;
    endfunction

    task automatic drain();
        while (pend.size() > 0 && pend[0].due <= cyc) begin
            led1_m = pend[0].pass;
            if (!pend[0].pass) led2_m = 1'b1;
            void'(pend.pop_front());
        end
    endtask

    task automatic step(input logic [1:0] op, input logic b, input logic [AW-1:0] a, input logic [35:0] d);
        pend_t p;
        @(negedge clk);
        if (en_a || en_b) chk("bus_owner", dq_rd, tb_val);
        gclop_in = {op, b, a, d};
        if (op == WR) mem_m[key(b, a)] = d;
        if (op == RD) begin
            p.due  = cyc + 5;
            p.pass = (mem_rd(b, a) == d);
            pend.push_back(p);
        end
        @(posedge clk);
        #1;
        drain();
        chk("led1_model", LED1, led1_m);
        chk("led2_model", LED2, led2_m);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            gclop_in = '0;
            @(posedge clk);
            #1;
            drain();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        gclop_in = '0;
        pend.delete();
        led1_m = 1'b0;
        led2_m = 1'b0;
    endtask

    typedef struct {
        logic [1:0]    op;
        logic          bank;
        logic [AW-1:0] addr;
        logic [35:0]   data;
        logic          exp1;
        logic          exp2;
    } vec_t;
    vec_t vt[7];

    initial begin
        vt[0] = '{WR, 1'b0, 18'h5, 36'h123456789, 1'b1, 1'b0};
        vt[1] = '{RD, 1'b0, 18'h5, 36'h123456789, 1'b1, 1'b0};
        vt[2] = '{WR, 1'b1, 18'h5, 36'h0AAAAAAAA, 1'b1, 1'b0};
        vt[3] = '{RD, 1'b0, 18'h5, 36'h123456789, 1'b1, 1'b0};
        vt[4] = '{RD, 1'b1, 18'h5, 36'h0AAAAAAAA, 1'b1, 1'b0};
        vt[5] = '{RD, 1'b0, 18'h5, 36'h000000000, 1'b0, 1'b1};
        vt[6] = '{RD, 1'b0, 18'h5, 36'h123456789, 1'b1, 1'b1};

        for (int i = 0; i < (1 << AW); i++) begin
            sram_a[i] = '0;
            sram_b[i] = '0;
        end

        // Reset state and release
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ce_n", CE_n, 1'b1);   chk("rst_ce2", CE2, 1'b0);   chk("rst_ce2_n", CE2_n, 1'b1);
        chk("rst_bw", {BWa_n, BWb_n, BWc_n, BWd_n}, 4'hF);
        chk("rst_we", {WE_n_A, WE_n_B}, 2'b11);  chk("rst_oe", {OE_n_A, OE_n_B}, 2'b11);
        chk("rst_adv", {ADV_A, ADV_B}, 2'b00);   chk("rst_addr", {A_A, A_B}, 36'd0);
        chk("rst_leds", {LED1, LED2}, 2'b00);
        probe_en = 1'b1;
        #1 chk("rst_dq_free", dq_rd, PROBE);
        probe_en = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ce_n", CE_n, 1'b0);  chk("ce2", CE2, 1'b1);  chk("ce2_n", CE2_n, 1'b0);
        chk("bw", {BWa_n, BWb_n, BWc_n, BWd_n}, 4'h0);
        chk("static", {CKE_n, ZZ, FT_n, MODE}, 4'b0010);

        // Issue and data-cycle timing, WRITE A@3 then READ A@3
        step(WR, 1'b0, 18'h3, 36'hC0FFEE123);
        chk("wr_we_a", WE_n_A, 1'b0);  chk("wr_addr_a", A_A, 18'h3);
        chk("wr_we_b", WE_n_B, 1'b1);  chk("wr_adv_a", ADV_A, 1'b0);
        step(RD, 1'b0, 18'h3, 36'hC0FFEE123);
        chk("rd_we_a", WE_n_A, 1'b1);  chk("rd_addr_a", A_A, 18'h3);  chk("idle_addr_b", A_B, 18'h0);
        step(NOP, 1'b0, 18'h0, 36'h0);
        chk("wr_dcyc_oe", OE_n_A, 1'b1);  chk("wr_dcyc_dq", dq_rd, 36'hC0FFEE123);
        step(NOP, 1'b0, 18'h0, 36'h0);
        chk("rd_dcyc_oe_a", OE_n_A, 1'b0);  chk("rd_dcyc_oe_b", OE_n_B, 1'b1);
        step(NOP, 1'b0, 18'h0, 36'h0);
        chk("rd_e3_oe_a", OE_n_A, 1'b1);  chk("rd_e3_led1", LED1, 1'b0);
        step(NOP, 1'b0, 18'h0, 36'h0);
        chk("rd_e4_led1", LED1, 1'b1);

        // Directed table: bank isolation, mismatch, sticky error
        for (int i = 0; i < 7; i++) begin
            step(vt[i].op, vt[i].bank, vt[i].addr, vt[i].data);
            repeat (4) step(NOP, 1'b0, 18'h0, 36'h0);
            chk($sformatf("vec%0d_led1", i), LED1, vt[i].exp1);
            chk($sformatf("vec%0d_led2", i), LED2, vt[i].exp2);
        end
        chk("vec_idle_b", A_B, 18'h5);

        // Back-to-back alternating WRITE/READ on both banks, all expected to pass
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [63:0]   r;
            logic          b;
            logic [AW-1:0] a;
            r = {$urandom(), $urandom()};
            b = 1'($urandom_range(0, 1));
            a = 18'($urandom_range(0, 15));
            if (i % 2 == 0) step(WR, b, a, r[35:0]);
            else            step(RD, b, a, mem_rd(b, a));
        end
        repeat (5) step(NOP, 1'b0, 18'h0, 36'h0);
        chk("alt_no_err", LED2, 1'b0);

        // Mixed random traffic with occasional wrong expectations and opcode 11
        for (int i = 0; i < 250; i++) begin
            logic [63:0]   r;
            logic [1:0]    op;
            logic          b;
            logic [AW-1:0] a;
            r  = {$urandom(), $urandom()};
            op = 2'($urandom_range(0, 3));
            b  = 1'($urandom_range(0, 1));
            a  = 18'($urandom_range(0, 15));
            if (op == RD) step(RD, b, a, mem_rd(b, a) ^ (($urandom_range(0, 9) == 0) ? 36'h1 : 36'h0));
            else          step(op, b, a, r[35:0]);
        end
        repeat (5) step(NOP, 1'b0, 18'h0, 36'h0);

        // JMP1N halt: held WRITE never reaches the bank
        do_reset();
        @(negedge clk) JMP1N = 1'b1;
        tick(3);
        @(negedge clk) gclop_in = {WR, 1'b1, 18'h5, 36'h111111111};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("halt_we_b", WE_n_B, 1'b1);
            chk("halt_we_a", WE_n_A, 1'b1);
        end
        @(negedge clk) begin gclop_in = '0; JMP1N = 1'b0; end
        tick(3);
        step(RD, 1'b1, 18'h5, mem_rd(1'b1, 18'h5));
        repeat (4) step(NOP, 1'b0, 18'h0, 36'h0);
        chk("halt_mem_kept", LED1, 1'b1);

        // JMP1S forces LEDs without touching the flags
        @(negedge clk) JMP1S = 1'b1;
        tick(3);
        chk("js_led1", LED1, 1'b1);
        chk("js_led2", LED2, 1'b1);
        @(negedge clk) JMP1S = 1'b0;
        tick(3);
        chk("js_off_led2", LED2, 1'b0);

        // Reset in the data cycle of a failing READ
        do_reset();
        @(negedge clk) gclop_in = {RD, 1'b0, 18'h7, mem_rd(1'b0, 18'h7) ^ 36'h1};
        @(posedge clk);
        @(negedge clk) gclop_in = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("mid_oe_low", OE_n_A, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mid_oe_off", OE_n_A, 1'b1);
        chk("mid_led2", LED2, 1'b0);
        probe_en = 1'b1;
        #1 chk("mid_dq_free", dq_rd, PROBE);
        probe_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        tick(6);
        chk("post_led2", LED2, 1'b0);
        chk("post_led1", LED1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
